m0_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter for the M0 design. It feeds the serial

---
 rtl/m0_serializer.sv | 117 +++++++++++
 tb/tb_m0_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/m0_serializer.sv
// rtl/m0_serializer.sv - parallel-in/serial-out word transmitter, LSB first, with inter-word gap
module m0_serializer #(
    parameter int WIDTH    = 16,
    parameter int DIV      = 1,
    parameter int GAP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             sout,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             div_last, bit_last, gap_last;
    logic             sout_d, frame_d, ready_d, busy_d, done_d;

    assign div_last = (div_cnt == DIV_MAX);
    assign bit_last = (bit_cnt == BIT_MAX);
    assign gap_last = (gap_cnt == GAP_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (valid) next_state = SHIFT;
            SHIFT: if (div_last && bit_last) next_state = (GAP_BITS > 0) ? GAP : IDLE;
            GAP:   if (div_last && gap_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are computed for the upcoming cycle so every port comes straight from a flop.
    always_comb begin
        frame_d = (next_state == SHIFT);
        ready_d = (next_state == IDLE);
        busy_d  = ~ready_d;
        done_d  = (state == SHIFT) && (next_state != SHIFT);
        sout_d  = 1'b0;
        if (frame_d) begin
            if (state == IDLE) sout_d = data_in[0];
            else               sout_d = div_last ? shreg[1] : shreg[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            sout    <= 1'b0;
            frame   <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sout  <= sout_d;
            frame <= frame_d;
            ready <= ready_d;
            busy  <= busy_d;
            done  <= done_d;
            case (state)
                IDLE: begin
                    if (valid) shreg <= data_in;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    gap_cnt <= '0;
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                GAP: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        gap_cnt <= gap_last ? '0 : gap_cnt + GW'(1);
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m0_serializer.sv
// tb/tb_m0_serializer.sv - self-checking bench for m0_serializer across three parameter sets
module tb_m0_serializer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // a: DIV=1 GAP=1, b: DIV=4 GAP=1, c: DIV=1 GAP=0
    logic [W-1:0] da = '0, db = '0, dc = '0;
    logic va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic ra, sa, fa, ba, oa;
    logic rb, sb, fb, bb, ob;
    logic rc, sc, fc, bc, oc;

    m0_serializer #(.WIDTH(W), .DIV(1), .GAP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .data_in(da), .valid(va),
        .ready(ra), .sout(sa), .frame(fa), .busy(ba), .done(oa));
    m0_serializer #(.WIDTH(W), .DIV(4), .GAP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .data_in(db), .valid(vb),
        .ready(rb), .sout(sb), .frame(fb), .busy(bb), .done(ob));
    m0_serializer #(.WIDTH(W), .DIV(1), .GAP_BITS(0)) u_c (
        .clk(clk), .rst(rst), .data_in(dc), .valid(vc),
        .ready(rc), .sout(sc), .frame(fc), .busy(bc), .done(oc));

    // Expected {sout, frame, done, ready, busy} in cycle n after the handshake edge.
    function automatic logic [4:0] expect_at(input logic [W-1:0] w, input int div,
                                             input int gap, input int n);
        logic s, f, d, r;
        int nb;
        nb = W * div;
        f  = (n >= 1) && (n <= nb);
        s  = f ? w[(n - 1) / div] : 1'b0;
        d  = (n == nb + 1);
        r  = (n > (W + gap) * div);
        return {s, f, d, r, ~r};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({sa, fa, oa, ra, ba} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_a: got %b want 00010", {sa, fa, oa, ra, ba});
        end
        n_checks++;
        if ({sb, fb, ob, rb, bb} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_b: got %b want 00010", {sb, fb, ob, rb, bb});
        end
        n_checks++;
        if ({sc, fc, oc, rc, bc} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_c: got %b want 00010", {sc, fc, oc, rc, bc});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] w;
        logic [4:0] e;
        for (int k = 0; k < 5; k++) begin
            w  = (k == 0) ? 16'hA5C3 : W'($urandom);
            da = w;
            va = 1'b1;
            for (int n = 1; n <= (W + 1) + 1; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    va = 1'b0;
                    da = W'($urandom);
                end
                e = expect_at(w, 1, 1, n);
                n_checks++;
                if ({sa, fa, oa, ra, ba} !== e) begin
                    n_fail++;
                    $display("FAIL basic w=%h cycle %0d: got %b want %b", w, n, {sa, fa, oa, ra, ba}, e);
                end
            end
        end
    endtask

    task automatic test_stretch();
        logic [W-1:0] w;
        logic [4:0] e;
        for (int k = 0; k < 3; k++) begin
            w  = (k == 0) ? 16'h0001 : W'($urandom);
            db = w;
            vb = 1'b1;
            for (int n = 1; n <= (W + 1) * 4 + 1; n++) begin
                @(negedge clk);
                if (n == 1) vb = 1'b0;
                e = expect_at(w, 4, 1, n);
                n_checks++;
                if ({sb, fb, ob, rb, bb} !== e) begin
                    n_fail++;
                    $display("FAIL stretch w=%h cycle %0d: got %b want %b", w, n, {sb, fb, ob, rb, bb}, e);
                end
            end
        end
    endtask

    task automatic test_busy();
        logic [W-1:0] w;
        logic [4:0] e;
        w  = W'($urandom) & 16'h7FFF;
        da = w;
        va = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (n == 8) da = 16'hFFFF;
            e = expect_at(w, 1, 1, n);
            n_checks++;
            if ({sa, fa, oa, ra, ba} !== e) begin
                n_fail++;
                $display("FAIL busy first w=%h cycle %0d: got %b want %b", w, n, {sa, fa, oa, ra, ba}, e);
            end
        end
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (n == 1) va = 1'b0;
            e = expect_at(16'hFFFF, 1, 1, n);
            n_checks++;
            if ({sa, fa, oa, ra, ba} !== e) begin
                n_fail++;
                $display("FAIL busy second cycle %0d: got %b want %b", n, {sa, fa, oa, ra, ba}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        logic [4:0] e;
        w  = W'($urandom) | 16'h0080;
        da = w;
        va = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) va = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({sa, fa, oa, ra, ba} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_mid async: got %b want 00010", {sa, fa, oa, ra, ba});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            n_checks++;
            if ({sa, fa, oa, ra, ba} !== 5'b00010) begin
                n_fail++;
                $display("FAIL reset_mid idle cycle %0d: got %b want 00010", n, {sa, fa, oa, ra, ba});
            end
        end
        da = 16'h8000;
        va = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (n == 1) va = 1'b0;
            e = expect_at(16'h8000, 1, 1, n);
            n_checks++;
            if ({sa, fa, oa, ra, ba} !== e) begin
                n_fail++;
                $display("FAIL reset_mid resend cycle %0d: got %b want %b", n, {sa, fa, oa, ra, ba}, e);
            end
        end
    endtask

    task automatic test_no_gap();
        logic [4:0] e;
        dc = 16'h00FF;
        vc = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 1) dc = 16'hFF00;
            e = expect_at(16'h00FF, 1, 0, n);
            n_checks++;
            if ({sc, fc, oc, rc, bc} !== e) begin
                n_fail++;
                $display("FAIL no_gap first cycle %0d: got %b want %b", n, {sc, fc, oc, rc, bc}, e);
            end
        end
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 1) vc = 1'b0;
            e = expect_at(16'hFF00, 1, 0, n);
            n_checks++;
            if ({sc, fc, oc, rc, bc} !== e) begin
                n_fail++;
                $display("FAIL no_gap second cycle %0d: got %b want %b", n + 17, {sc, fc, oc, rc, bc}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stretch();
        test_busy();
        test_reset_mid();
        test_no_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
